stopwatch_counter: RTL and testbench
====================================

# stopwatch_counter

Count-up mm:ss stopwatch, the counterpart of the lab's countdown timer. It sits between the debounce/one-pulse front end and the Seven_SEG display driver. It counts whole seconds up from 00:00 on a one-cycle tick strobe, and saturates at 59:59 with a `full` flag, mirroring the countdown timer's `stop` at zero. It supplies four BCD digits directly to the display driver.

## Interface
- `MAX_SEC`, default 3599: terminal count in seconds (59:59). Must stay ≤ 3599.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `tick`  in  1  one-`clk`-cycle strobe, once per second (from the clock divider/one-pulse chain).
- `start_stop`  in  1  one-pulse; toggles run/pause.
- `clear`  in  1  one-pulse; return to 00:00, idle.
- `lap`  in  1  one-pulse; capture/release the displayed value (only with `LAP_HOLD_EN`).
- `bcd`  out  16  {min tens, min units, sec tens, sec units}; each nibble 0–9; sec tens 0–5, min tens 0–5.
- `running`  out  1  high in RUN.
- `full`  out  1  high in FULL.
- `lap_active`  out  1  displayed value is frozen (constant 0 without `LAP_HOLD_EN`).

## Operation
- States: IDLE, RUN, PAUSE, FULL. Encoded in the package enum.
- IDLE: count = 0. `start_stop` → RUN.
- RUN: each `tick` increments count. A tick that brings count to `MAX_SEC` → FULL. `start_stop` → PAUSE.
- PAUSE: ticks ignored, count held. `start_stop` → RUN.
- FULL: count held at `MAX_SEC`; ticks and `start_stop` ignored; only `clear` or reset leaves it.
- `clear` in any state → IDLE, count = 0, lap released.
- Priority within one cycle: `clear` > `start_stop` > `tick`.
  - `start_stop` with `tick` in RUN: go to PAUSE, no increment.
  - `start_stop` with `tick` in PAUSE: go to RUN, no increment on that cycle.
- Counting is done directly in BCD, with no binary-to-BCD divider:
  - sec units wraps 9→0 and carries to sec tens.
  - sec tens wraps 5→0 and carries to min units.
  - min units wraps 9→0 and carries to min tens.
- Count never exceeds `MAX_SEC`, so min tens never wraps.

## Timing
- Reset (asynchronous assert, synchronous release): state IDLE, count 00:00, `bcd` = 16'h0000, `running` = 0, `full` = 0, `lap_active` = 0.
- All outputs are registered. `bcd` reflects an increment one `clk` after the tick cycle.
- `running` and `full` change on the same edge as the state register.
- `full` rises on the same edge that loads 59:59.
- Reset asserted mid-count: outputs go to reset values immediately. A tick pending on that cycle is lost.

## Configuration
- `STOPWATCH_LAP_HOLD_EN` defined:
  - `lap` pulse with `lap_active` = 0, in RUN or PAUSE: copy the live count into the lap register and set `lap_active`. `bcd` shows the lap register.
  - Next `lap` pulse: clear `lap_active`; `bcd` shows the live count on the following edge.
  - Live count keeps advancing underneath.
  - `lap` is ignored in IDLE and FULL.
  - `clear` releases the lap.
- Not defined: `lap` input ignored, `lap_active` tied 0, no lap register, `bcd` is always the live count.

## Structure
- Package `stopwatch_pkg`: state enum, `SEC_TENS_MAX` = 5, `DIGIT_MAX` = 9, default `MAX_SEC`.
- One sub-module, `bcd_digit_counter`, instantiated four times.
  - Parameter: wrap limit.
  - Ports: `clk`, `reset`, `clr`, `inc`, `digit[3:0]`, `carry`.
  - `carry` is combinational: `inc` && digit == limit.
- Saturation check compares the four digits against the BCD form of `MAX_SEC`.

## Test plan
- Reset, then `start_stop`, then 75 ticks → `bcd` = 16'h0115, `running` = 1.
- At 09:59 in RUN, one tick → `bcd` = 16'h1000, with carries through all digits.
- At 59:58 in RUN, two ticks then three more → `bcd` = 16'h5959, `full` = 1, `running` = 0. Further ticks and `start_stop` leave it unchanged.
- In RUN, `start_stop` with `tick` in the same cycle → PAUSE, no increment. Ten further ticks leave `bcd` unchanged.
- `clear` with `start_stop` and `tick` in the same cycle from RUN at 00:30 → IDLE, `bcd` = 16'h0000.
- With `STOPWATCH_LAP_HOLD_EN`: `lap` at 00:12, then 5 ticks → `bcd` = 16'h0012, `lap_active` = 1. Second `lap` → `bcd` = 16'h0017.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// stopwatch_counter shared types and constants.
// Optional lap-hold feature: define STOPWATCH_LAP_HOLD_EN.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        FULL  = 2'd3
    } sw_state_e;

    localparam int          BCD_W           = 16;
    localparam logic [3:0]  SEC_TENS_MAX    = 4'd5;
    localparam logic [3:0]  DIGIT_MAX       = 4'd9;
    localparam int          MAX_SEC_DEFAULT = 3599;

    // seconds -> {min tens, min units, sec tens, sec units}
    function automatic logic [BCD_W-1:0] to_bcd(input int s);
        int m;
        int r;
        m = s / 60;
        r = s % 60;
        return {4'(m / 10), 4'(m % 10), 4'(r / 10), 4'(r % 10)};
    endfunction

endpackage

// File: rtl/stopwatch_counter_if.sv
// Control strobes and display outputs of stopwatch_counter.
// master drives the strobes, slave is the stopwatch.
interface stopwatch_counter_if;
    import stopwatch_pkg::*;

    logic             tick;
    logic             start_stop;
    logic             clear;
    logic             lap;
    logic [BCD_W-1:0] bcd;
    logic             running;
    logic             full;
    logic             lap_active;

    modport master (
        output tick, start_stop, clear, lap,
        input  bcd, running, full, lap_active
    );

    modport slave (
        input  tick, start_stop, clear, lap,
        output bcd, running, full, lap_active
    );

endinterface

// File: rtl/stopwatch_counter_digit.sv
// One BCD digit with programmable wrap limit.
// carry is combinational so a chain ripples in one cycle.
module bcd_digit_counter
    import stopwatch_pkg::*;
#(
    parameter logic [3:0] LIMIT = DIGIT_MAX
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] digit,
    output logic       carry
);

    assign carry = inc && (digit == LIMIT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            digit <= 4'd0;
        end else if (clr) begin
            digit <= 4'd0;
        end else if (inc) begin
            digit <= carry ? 4'd0 : digit + 4'd1;
        end
    end

endmodule

// File: rtl/stopwatch_counter.sv
// Count-up mm:ss stopwatch, saturating at MAX_SEC.
// Lap hold built only with STOPWATCH_LAP_HOLD_EN defined.
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int MAX_SEC = MAX_SEC_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    stopwatch_counter_if.slave  sw
);

    localparam logic [BCD_W-1:0] MAX_BCD = to_bcd(MAX_SEC);
    localparam logic [BCD_W-1:0] PRE_BCD = to_bcd(MAX_SEC - 1);

    sw_state_e        state_q;
    sw_state_e        state_d;
    logic             running_q;
    logic             full_q;
    logic             inc;
    logic [2:0]       cy;
    logic [BCD_W-1:0] live;

    // start_stop and clear both preempt the tick
    assign inc = (state_q == RUN) && sw.tick && !sw.start_stop &&
                 !sw.clear && (live != MAX_BCD);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (sw.start_stop) state_d = RUN;
            RUN:     if (sw.start_stop) state_d = PAUSE;
                     else if (inc && live == PRE_BCD) state_d = FULL;
            PAUSE:   if (sw.start_stop) state_d = RUN;
            FULL:    state_d = FULL;
            default: state_d = IDLE;
        endcase
        if (sw.clear) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            running_q <= 1'b0;
            full_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            running_q <= (state_d == RUN);
            full_q    <= (state_d == FULL);
        end
    end

    bcd_digit_counter #(.LIMIT(DIGIT_MAX)) u_sec_u (
        .clk(clk), .reset(reset), .clr(sw.clear),
        .inc(inc), .digit(live[3:0]), .carry(cy[0])
    );

    bcd_digit_counter #(.LIMIT(SEC_TENS_MAX)) u_sec_t (
        .clk(clk), .reset(reset), .clr(sw.clear),
        .inc(cy[0]), .digit(live[7:4]), .carry(cy[1])
    );

    bcd_digit_counter #(.LIMIT(DIGIT_MAX)) u_min_u (
        .clk(clk), .reset(reset), .clr(sw.clear),
        .inc(cy[1]), .digit(live[11:8]), .carry(cy[2])
    );

    logic mt_carry_unused;

    bcd_digit_counter #(.LIMIT(SEC_TENS_MAX)) u_min_t (
        .clk(clk), .reset(reset), .clr(sw.clear),
        .inc(cy[2]), .digit(live[15:12]), .carry(mt_carry_unused)
    );

    assign sw.running = running_q;
    assign sw.full    = full_q;

`ifdef STOPWATCH_LAP_HOLD_EN
    logic [BCD_W-1:0] lap_q;
    logic             lap_act_q;
    logic             lap_ok;

    assign lap_ok = sw.lap && ((state_q == RUN) || (state_q == PAUSE));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lap_q     <= '0;
            lap_act_q <= 1'b0;
        end else if (sw.clear) begin
            lap_act_q <= 1'b0;
        end else if (lap_ok) begin
            if (!lap_act_q) lap_q <= live;
            lap_act_q <= !lap_act_q;
        end
    end

    assign sw.bcd        = lap_act_q ? lap_q : live;
    assign sw.lap_active = lap_act_q;
`else
    logic lap_unused;

    assign lap_unused    = sw.lap;
    assign sw.bcd        = live;
    assign sw.lap_active = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter, default MAX_SEC.
// Lap steps run only when STOPWATCH_LAP_HOLD_EN is defined.
module tb_stopwatch_counter;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    stopwatch_counter_if sw ();

    stopwatch_counter dut (
        .clk  (clk),
        .reset(reset),
        .sw   (sw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic t, input logic s,
                        input logic c, input logic l);
        @(negedge clk);
        sw.tick       = t;
        sw.start_stop = s;
        sw.clear      = c;
        sw.lap        = l;
        @(posedge clk);
        #1;
        sw.tick       = 1'b0;
        sw.start_stop = 1'b0;
        sw.clear      = 1'b0;
        sw.lap        = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        reset         = 1'b0;
        sw.tick       = 1'b0;
        sw.start_stop = 1'b0;
        sw.clear      = 1'b0;
        sw.lap        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_bcd", sw.bcd, 16'h0000);
        chk("rst_flags", {13'd0, sw.running, sw.full, sw.lap_active},
            16'h0000);
        @(negedge clk);
        reset = 1'b1;

        ticks(3);
        chk("idle_ignores_tick", sw.bcd, 16'h0000);

        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("run_flag", {15'd0, sw.running}, 16'h0001);
        ticks(75);
        chk("t75_bcd", sw.bcd, 16'h0115);
        chk("t75_run", {15'd0, sw.running}, 16'h0001);

        ticks(524);
        chk("t599_bcd", sw.bcd, 16'h0959);
        ticks(1);
        chk("t600_carry", sw.bcd, 16'h1000);

        ticks(2998);
        chk("t3598_bcd", sw.bcd, 16'h5958);
        chk("t3598_flags", {14'd0, sw.running, sw.full}, 16'h0002);
        ticks(1);
        chk("full_bcd", sw.bcd, 16'h5959);
        chk("full_same_edge", {14'd0, sw.running, sw.full}, 16'h0001);
        ticks(1);
        chk("full_hold", sw.bcd, 16'h5959);
        ticks(3);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("full_ss_bcd", sw.bcd, 16'h5959);
        chk("full_ss_flags", {14'd0, sw.running, sw.full}, 16'h0001);

        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("clr_full_bcd", sw.bcd, 16'h0000);
        chk("clr_full_flags", {14'd0, sw.running, sw.full}, 16'h0000);

        step(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(7);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("pause_no_inc", sw.bcd, 16'h0007);
        chk("pause_flag", {15'd0, sw.running}, 16'h0000);
        ticks(10);
        chk("pause_hold", sw.bcd, 16'h0007);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("resume_no_inc", sw.bcd, 16'h0007);
        chk("resume_flag", {15'd0, sw.running}, 16'h0001);
        ticks(23);
        chk("t30_bcd", sw.bcd, 16'h0030);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk("clr_prio_bcd", sw.bcd, 16'h0000);
        chk("clr_prio_flags", {14'd0, sw.running, sw.full}, 16'h0000);

        step(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(12);
`ifdef STOPWATCH_LAP_HOLD_EN
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("lap_cap", sw.bcd, 16'h0012);
        ticks(5);
        chk("lap_hold_bcd", sw.bcd, 16'h0012);
        chk("lap_hold_act", {15'd0, sw.lap_active}, 16'h0001);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("lap_rel_bcd", sw.bcd, 16'h0017);
        chk("lap_rel_act", {15'd0, sw.lap_active}, 16'h0000);
`else
        step(1'b0, 1'b0, 1'b0, 1'b1);
        ticks(5);
        chk("nolap_bcd", sw.bcd, 16'h0017);
        chk("nolap_act", {15'd0, sw.lap_active}, 16'h0000);
`endif

        ticks(3);
        chk("pre_rst_bcd", sw.bcd, 16'h0020);
        @(negedge clk);
        sw.tick = 1'b1;
        reset   = 1'b0;
        #1;
        chk("async_rst_bcd", sw.bcd, 16'h0000);
        chk("async_rst_flags", {13'd0, sw.running, sw.full, sw.lap_active},
            16'h0000);
        @(posedge clk);
        #1;
        chk("rst_tick_lost", sw.bcd, 16'h0000);
        @(negedge clk);
        sw.tick = 1'b0;
        reset   = 1'b1;
        ticks(2);
        chk("post_rst_idle", sw.bcd, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
